fetch_stage_ctrl: RTL
=====================

// Module: fetch_stage_ctrl
// PURPOSE
//  Fetch-side consumer of the hazard detection unit's stall requests. Owns the
//  program counter, the IF/ID pipeline register and the ID/EX bubble request.
//  Applies PC hold, IF/ID hold and ID/EX bubble on a load-use stall, and
//  redirects and flushes on a branch taken in EX. Keeps stall/flush counters
//  and a sticky error flag for inconsistent hazard controls.
// PARAMETERS
//  PC_W      8      program counter / instruction memory address width
//  INSTR_W   16     instruction width
//  RESET_PC  0      PC value loaded on reset
//  NOP_INSTR 0      encoding inserted on flush/bubble
//  CNT_W     8      width of saturating stall/flush counters
// PORTS
//  clk             in   1        single clock, all state updates on rising edge
//  rst_n           in   1        synchronous, active-low reset
//  inc_ProgCtr     in   1        1 = PC may advance, 0 = hold PC
//  write_IFID      in   1        1 = IF/ID may load, 0 = hold IF/ID
//  stall_id        in   1        1 = insert bubble into ID/EX next cycle
//  branch_taken_ex in   1        branch/jump resolved taken in EX
//  branch_tgt_ex   in   PC_W     redirect target from EX
//  imem_addr       out  PC_W     instruction memory address (= pc, combinational)
//  imem_rdata      in   INSTR_W  instruction at imem_addr, same-cycle (async ROM)
//  ifid_instr      out  INSTR_W  IF/ID instruction register
//  ifid_pc         out  PC_W     PC of ifid_instr
//  ifid_valid      out  1        ifid_instr is a real fetched instruction
//  idex_bubble     out  1        registered: ID/EX must load NOP this cycle
//  stall_cnt       out  CNT_W    saturating count of load-use stall cycles
//  flush_cnt       out  CNT_W    saturating count of branch flushes
//  ctrl_err        out  1        sticky: inc_ProgCtr != write_IFID seen
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): pc=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=0,
//   ifid_valid=0, idex_bubble=1, stall_cnt=0, flush_cnt=0, ctrl_err=0.
//   Reset overrides all inputs in the same cycle; mid-stall/mid-flush reset
//   discards everything; first fetch from RESET_PC in cycle after release.
//  PC next-state, priority order:
//   1 branch_taken_ex        -> pc <= branch_tgt_ex
//   2 !inc_ProgCtr           -> pc holds
//   3 otherwise              -> pc <= pc+1, wraps mod 2^PC_W (max -> 0)
//  IF/ID next-state, priority order:
//   1 branch_taken_ex        -> instr<=NOP_INSTR, pc<=0, valid<=0 (flush wins
//                               over write_IFID=0)
//   2 write_IFID             -> instr<=imem_rdata, ifid_pc<=pc, valid<=1
//   3 otherwise              -> hold all three
//  idex_bubble <= stall_id | branch_taken_ex (one-cycle latency; branch also
//   kills the instruction currently in ID).
//  stall_cnt  +1 on cycles with stall_id=1 and branch_taken_ex=0; saturates
//   at 2^CNT_W-1.
//  flush_cnt  +1 on cycles with branch_taken_ex=1; saturates likewise.
//  ctrl_err   set on any cycle (out of reset) with inc_ProgCtr!=write_IFID;
//   cleared only by reset. Datapath still obeys each signal independently.
//  Stall latency: a stall asserted in cycle N freezes pc and IF/ID at edge N,
//   so the same instruction is re-presented to ID in N+1.
//  Back-to-back stalls hold indefinitely; no internal timeout.
// TESTING
//  1 reset, rst_n=1, no hazards, imem[k]=0x1000+k -> ifid_instr 0x1000,0x1001,
//    ... ifid_pc 0,1,... ifid_valid=1 from 2nd edge; idex_bubble 1 then 0.
//  2 load-use: hold stall_id=1, inc=0, wIFID=0 for 1 cycle at pc=5 -> pc stays
//    5, ifid holds instr@4 for one extra cycle, idex_bubble=1 next cycle,
//    stall_cnt=1.
//  3 branch_taken_ex=1, tgt=0x40 at pc=9 -> next pc=0x40, ifid_valid=0,
//    ifid_instr=NOP, idex_bubble=1, flush_cnt=1; then fetch 0x40,0x41.
//  4 branch and stall same cycle -> redirect+flush win, pc=tgt, stall_cnt
//    unchanged, flush_cnt+1.
//  5 pc=0xFF, no hazard -> pc=0x00; force 300 stall cycles -> stall_cnt=255.
//  6 inc_ProgCtr=0, write_IFID=1 one cycle -> ctrl_err=1 sticky; pc holds,
//    ifid loads; rst_n=0 mid-stall -> all outputs at reset values next edge.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// Fetch-side stall/flush controller: owns the PC, the IF/ID register and the ID/EX
// bubble request, and tracks stall/flush statistics plus a sticky control-error flag.
module fetch_stage_ctrl #(
  parameter int unsigned         PC_W      = 8,
  parameter int unsigned         INSTR_W   = 16,
  parameter logic [PC_W-1:0]     RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
  parameter int unsigned         CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc_ProgCtr,
  input  logic               write_IFID,
  input  logic               stall_id,
  input  logic               branch_taken_ex,
  input  logic [PC_W-1:0]    branch_tgt_ex,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic               idex_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic               ctrl_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ifid_instr_d;
  logic [PC_W-1:0]    ifid_pc_d;
  logic               ifid_valid_d;
  logic               idex_bubble_d;
  logic [CNT_W-1:0]   stall_cnt_d, flush_cnt_d;
  logic               ctrl_err_d;
  logic               stall_cycle;

  // The async ROM is addressed directly by the live PC.
  assign imem_addr = pc_q;

  // A branch in the same cycle wins over the stall, so that cycle is not counted as a stall.
  assign stall_cycle = stall_id & ~branch_taken_ex;

  // Next-state: redirect beats hold, hold beats increment.
  always_comb begin
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr;
    ifid_pc_d     = ifid_pc;
    ifid_valid_d  = ifid_valid;
    idex_bubble_d = stall_id | branch_taken_ex;
    stall_cnt_d   = stall_cnt;
    flush_cnt_d   = flush_cnt;
    ctrl_err_d    = ctrl_err | (inc_ProgCtr != write_IFID);

    if (branch_taken_ex) begin
      pc_d = branch_tgt_ex;
    end else if (inc_ProgCtr) begin
      pc_d = pc_q + PC_W'(1);
    end

    if (branch_taken_ex) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end else if (write_IFID) begin
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pc_q;
      ifid_valid_d = 1'b1;
    end

    if (stall_cycle && stall_cnt != CNT_MAX) begin
      stall_cnt_d = stall_cnt + CNT_W'(1);
    end
    if (branch_taken_ex && flush_cnt != CNT_MAX) begin
      flush_cnt_d = flush_cnt + CNT_W'(1);
    end
  end

  // State register; reset overrides every input in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= '0;
      ifid_valid  <= 1'b0;
      idex_bubble <= 1'b1;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      ctrl_err    <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifid_instr  <= ifid_instr_d;
      ifid_pc     <= ifid_pc_d;
      ifid_valid  <= ifid_valid_d;
      idex_bubble <= idex_bubble_d;
      stall_cnt   <= stall_cnt_d;
      flush_cnt   <= flush_cnt_d;
      ctrl_err    <= ctrl_err_d;
    end
  end

endmodule
